// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown alarm timer.
// State encoding is exported on the debug/LED state port.
package timer_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    BEEP  = 2'd3
  } state_t;

  localparam int unsigned LOAD_W = 32;

  // Seconds to ticks, clamped to the largest count the output can show.
  function automatic logic [LOAD_W-1:0] sat_load(
    input logic [LOAD_W-1:0] sec,
    input int unsigned       tick_hz,
    input int unsigned       out_w
  );
    logic [63:0] prod;
    logic [63:0] lim;
    prod = 64'(sec) * 64'(tick_hz);
    lim  = (64'd1 << out_w) - 64'd1;
    if (prod > lim) begin
      return lim[LOAD_W-1:0];
    end
    return prod[LOAD_W-1:0];
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Button/switch inputs and display/buzzer outputs of the timer.
// master = board side, slave = timer controller.
interface countdown_timer_ctrl_if #(
  parameter int unsigned SEC_W = 9,
  parameter int unsigned OUT_W = 16
);
  import timer_pkg::*;

  logic             start_n;
  logic             clear_n;
  logic [SEC_W-1:0] switches;
  logic [OUT_W-1:0] count;
  logic             flash;
  logic             buzzer;
  state_t           state;

  modport master (
    output start_n,
    output clear_n,
    output switches,
    input  count,
    input  flash,
    input  buzzer,
    input  state
  );

  modport slave (
    input  start_n,
    input  clear_n,
    input  switches,
    output count,
    output flash,
    output buzzer,
    output state
  );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_HZ/TICK_HZ clocks.
// en freezes the phase (no reset), clr restarts it.
module tick_prescaler #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown alarm controller: SET/RUN/PAUSE/BEEP with blink and buzzer.
// Define AUTO_SILENCE_EN to stop the buzzer after BEEP_TICKS ticks.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned SEC_W      = 9,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned FLASH_DIV  = 25,
  parameter int unsigned BEEP_TICKS = 1000
) (
  input logic                 clk,
  input logic                 rst_n,
  countdown_timer_ctrl_if.slave bus
);

`ifdef AUTO_SILENCE_EN
  localparam bit AUTO_SIL = 1'b1;
`else
  localparam bit AUTO_SIL = 1'b0;
`endif

  localparam int unsigned BW = $clog2(FLASH_DIV + 1);
  localparam int unsigned SW = $clog2(BEEP_TICKS + 1);
  localparam logic [BW-1:0] BLAST = BW'(FLASH_DIV - 1);
  localparam logic [SW-1:0] SLAST = SW'(BEEP_TICKS);

  // [0],[1] synchronise, [2] remembers the previous synced level
  logic [2:0] st_sr;
  logic [2:0] cl_sr;
  logic       start_p;
  logic       clear_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_sr <= '1;
      cl_sr <= '1;
    end else begin
      st_sr <= {st_sr[1:0], bus.start_n};
      cl_sr <= {cl_sr[1:0], bus.clear_n};
    end
  end

  assign start_p = st_sr[2] & ~st_sr[1];
  assign clear_p = cl_sr[2] & ~cl_sr[1];

  logic [OUT_W-1:0] load;

  assign load = OUT_W'(sat_load(LOAD_W'(bus.switches),
                                TICK_HZ, OUT_W));

  state_t           state_q;
  state_t           state_d;
  logic [OUT_W-1:0] count_q;
  logic [OUT_W-1:0] count_d;
  logic             flash_q;
  logic             flash_d;
  logic             buzz_q;
  logic             buzz_d;
  logic [BW-1:0]    bcnt_q;
  logic [BW-1:0]    bcnt_d;
  logic [SW-1:0]    scnt_q;
  logic [SW-1:0]    scnt_d;

  logic run_tick;
  logic free_tick;
  logic run_en;
  logic run_clr;

  assign run_en  = (state_q == RUN);
  assign run_clr = (state_q == SET);

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_run_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run_en),
    .clr   (run_clr),
    .tick  (run_tick)
  );

  tick_prescaler #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ)
  ) u_free_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (1'b0),
    .tick  (free_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SET;
      count_q <= '0;
      flash_q <= 1'b0;
      buzz_q  <= 1'b0;
      bcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flash_q <= flash_d;
      buzz_q  <= buzz_d;
      bcnt_q  <= bcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  logic blinking;
  logic entering;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    flash_d  = flash_q;
    bcnt_d   = bcnt_q;
    scnt_d   = scnt_q;
    buzz_d   = 1'b0;
    blinking = 1'b0;
    entering = 1'b0;

    unique case (state_q)
      SET: begin
        if (start_p && !clear_p) begin
          state_d = (load == '0) ? BEEP : RUN;
        end
      end
      RUN: begin
        if (clear_p) begin
          state_d = SET;
        end else if (start_p) begin
          state_d = PAUSE;
        end else if (run_tick) begin
          // the tick that empties the count also raises the alarm
          if (count_q <= OUT_W'(1)) begin
            state_d = BEEP;
          end else begin
            count_d = count_q - OUT_W'(1);
          end
        end
      end
      PAUSE: begin
        if (clear_p) begin
          state_d = SET;
        end else if (start_p) begin
          state_d = RUN;
        end
      end
      BEEP: begin
        if (clear_p) begin
          state_d = SET;
        end
      end
      default: state_d = SET;
    endcase

    if (state_d == SET) begin
      count_d = load;
    end
    if (state_d == BEEP) begin
      count_d = '0;
    end

    blinking = (state_d == PAUSE) || (state_d == BEEP);
    entering = blinking && (state_d != state_q);

    if (!blinking) begin
      flash_d = 1'b0;
      bcnt_d  = '0;
    end else if (entering) begin
      flash_d = 1'b1;
      bcnt_d  = '0;
      scnt_d  = '0;
    end else if (free_tick) begin
      if (bcnt_q == BLAST) begin
        bcnt_d  = '0;
        flash_d = ~flash_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
      if (scnt_q != SLAST) begin
        scnt_d = scnt_q + SW'(1);
      end
    end

    buzz_d = (state_d == BEEP) &&
             (!AUTO_SIL || (scnt_d != SLAST));
  end

  assign bus.state  = state_q;
  assign bus.count  = count_q;
  assign bus.flash  = flash_q;
  assign bus.buzzer = buzz_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: load table, timed sequences,
// and a random run against an event-level reference model.
module tb_countdown_timer_ctrl;
  import timer_pkg::*;

  localparam int PER   = 10;
  localparam int FDIV  = 2;
  localparam int BTKS  = 20;
  localparam int MAXC  = 32767;
`ifdef AUTO_SILENCE_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl_if #(.SEC_W(9), .OUT_W(15)) bus ();

  countdown_timer_ctrl #(
    .SEC_W      (9),
    .OUT_W      (15),
    .CLK_HZ     (1000),
    .TICK_HZ    (100),
    .FLASH_DIV  (FDIV),
    .BEEP_TICKS (BTKS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int sw;
    int cnt;
  } vec_t;

  vec_t tbl[6];

  // reference model: event-level view of the timer
  state_t m_st;
  int     m_cnt, m_ph, m_g, m_n;
  bit     s_h[3];
  bit     c_h[3];

  function automatic int ref_load(int sw);
    return (sw * 100 > MAXC) ? MAXC : sw * 100;
  endfunction

  task automatic m_reset();
    m_st = SET; m_cnt = 0; m_ph = 0;
    m_g = 0; m_n = 0;
    for (int i = 0; i < 3; i++) begin
      s_h[i] = 1'b1; c_h[i] = 1'b1;
    end
  endtask

  task automatic m_edge(bit sb, bit cb, int sw);
    bit sp, cp, ft, rt;
    state_t nx;
    int ld;
    // a press reaches the FSM three edges after the button falls
    sp = s_h[2] && !s_h[1];
    cp = c_h[2] && !c_h[1];
    s_h[2] = s_h[1]; s_h[1] = s_h[0]; s_h[0] = sb;
    c_h[2] = c_h[1]; c_h[1] = c_h[0]; c_h[0] = cb;
    m_g++;
    ft = (m_g % PER) == 0;
    rt = 1'b0;
    if (m_st == RUN) begin
      m_ph = (m_ph + 1) % PER;
      rt = (m_ph == 0);
    end
    ld = ref_load(sw);
    nx = m_st;
    case (m_st)
      SET:   if (sp && !cp) nx = (ld == 0) ? BEEP : RUN;
      RUN:   if (cp) nx = SET;
             else if (sp) nx = PAUSE;
             else if (rt) begin
               m_cnt--;
               if (m_cnt <= 0) nx = BEEP;
             end
      PAUSE: if (cp) nx = SET; else if (sp) nx = RUN;
      BEEP:  if (cp) nx = SET;
      default: nx = SET;
    endcase
    if (nx == SET) begin m_cnt = ld; m_ph = 0; end
    if (nx == BEEP) m_cnt = 0;
    if (nx != m_st && (nx == PAUSE || nx == BEEP)) m_n = 0;
    else if (ft) m_n++;
    m_st = nx;
  endtask

  function automatic int m_flash();
    if (m_st != PAUSE && m_st != BEEP) return 0;
    return ((m_n / FDIV) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int m_buzz();
    return (m_st == BEEP && (!AUTO || m_n < BTKS)) ? 1 : 0;
  endfunction

  initial begin
    int tog;
    bit pf, sb, cb;
    int sw;

    tbl[0] = '{0, 0};
    tbl[1] = '{1, 100};
    tbl[2] = '{3, 300};
    tbl[3] = '{327, 32700};
    tbl[4] = '{328, MAXC};
    tbl[5] = '{511, MAXC};

    bus.start_n = 1'b1; bus.clear_n = 1'b1;
    bus.switches = '0; rst_n = 1'b0;
    #2;
    chk("rst_state", bus.state, SET);
    chk("rst_count", bus.count, 0);
    chk("rst_flash", bus.flash, 0);
    chk("rst_buzz", bus.buzzer, 0);
    #10 rst_n = 1'b1;
    step(1);

    for (int i = 0; i < 6; i++) begin
      bus.switches = 9'(tbl[i].sw);
      step(2);
      chk($sformatf("load_sw%0d", tbl[i].sw),
          bus.count, tbl[i].cnt);
      chk("load_state", bus.state, SET);
    end

    // start from 3 s, first tick, run to alarm
    bus.switches = 9'd3; step(2);
    bus.start_n = 1'b0; step(2);
    chk("press_lat", bus.state, SET);
    step(1);
    chk("run_entry", bus.state, RUN);
    chk("run_300", bus.count, 300);
    bus.start_n = 1'b1;
    step(9);
    chk("pre_tick", bus.count, 300);
    step(1);
    chk("first_tick", bus.count, 299);
    step(2989);
    chk("cnt_one", bus.count, 1);
    chk("still_run", bus.state, RUN);
    step(1);
    chk("beep_state", bus.state, BEEP);
    chk("beep_count", bus.count, 0);
    chk("beep_buzz", bus.buzzer, 1);
    chk("beep_flash", bus.flash, 1);
    bus.start_n = 1'b0; step(5);
    chk("beep_ign_start", bus.state, BEEP);
    bus.start_n = 1'b1; step(3);

    // zero preset goes straight to alarm
    bus.clear_n = 1'b0; step(3);
    chk("clr_set", bus.state, SET);
    chk("clr_load", bus.count, 300);
    bus.clear_n = 1'b1; bus.switches = 9'd0; step(2);
    bus.start_n = 1'b0; step(3);
    chk("zero_beep", bus.state, BEEP);
    chk("zero_flash", bus.flash, 1);
    bus.start_n = 1'b1;
    tog = 0; pf = bus.flash;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (bus.flash != pf) tog++;
      pf = bus.flash;
      if (i == 189) chk("buzz_19t", bus.buzzer, 1);
    end
    chk("flash_toggles", tog, 10);
    chk("buzz_20t", bus.buzzer, AUTO ? 0 : 1);
    chk("beep_hold", bus.state, BEEP);
    bus.switches = 9'd2;
    bus.clear_n = 1'b0; step(3);
    chk("clr2_set", bus.state, SET);
    chk("clr2_load", bus.count, 200);
    chk("clr2_flash", bus.flash, 0);
    chk("clr2_buzz", bus.buzzer, 0);
    bus.clear_n = 1'b1; step(3);

    // pause mid-period, resume keeps the partial period
    bus.start_n = 1'b0; step(3);
    chk("p_run", bus.state, RUN);
    bus.start_n = 1'b1;
    step(500);
    chk("p_150", bus.count, 150);
    step(1);
    bus.start_n = 1'b0; step(3);
    chk("p_pause", bus.state, PAUSE);
    chk("p_flash", bus.flash, 1);
    bus.start_n = 1'b1;
    step(100);
    chk("p_held", bus.count, 150);
    chk("p_still", bus.state, PAUSE);
    bus.start_n = 1'b0; step(3);
    chk("p_resume", bus.state, RUN);
    bus.start_n = 1'b1;
    step(5);
    chk("p_pre", bus.count, 150);
    step(1);
    chk("p_dec6", bus.count, 149);

    // clear beats start; a held button is one press
    bus.start_n = 1'b0; bus.clear_n = 1'b0; step(3);
    chk("sc_set", bus.state, SET);
    bus.clear_n = 1'b1;
    step(50);
    chk("held_set", bus.state, SET);
    bus.start_n = 1'b1; step(3);
    bus.start_n = 1'b0; step(53);
    chk("held_run", bus.state, RUN);
    bus.start_n = 1'b1;

    // asynchronous reset while running
    step(5);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_state", bus.state, SET);
    chk("ar_count", bus.count, 0);
    chk("ar_flash", bus.flash, 0);
    chk("ar_buzz", bus.buzzer, 0);
    #3 rst_n = 1'b1;
    step(20);
    chk("idle_set", bus.state, SET);

    // random run against the model
    sb = 1'b1; cb = 1'b1; sw = 0;
    bus.start_n = sb; bus.clear_n = cb;
    bus.switches = '0;
    rst_n = 1'b0; #1 rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(99) < 2) sb = ~sb;
      if (cb) begin
        if ($urandom_range(999) < 3) cb = 1'b0;
      end else if ($urandom_range(99) < 20) begin
        cb = 1'b1;
      end
      if ($urandom_range(99) == 0) begin
        sw = ($urandom_range(9) < 7) ? int'($urandom_range(1))
                                     : int'($urandom_range(511));
      end
      bus.start_n = sb; bus.clear_n = cb;
      bus.switches = 9'(sw);
      @(posedge clk);
      m_edge(sb, cb, sw);
      #1;
      chk("r_state", bus.state, m_st);
      chk("r_count", bus.count, m_cnt);
      chk("r_flash", bus.flash, m_flash());
      chk("r_buzz", bus.buzzer, m_buzz());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
